rgb_pwm_capture: RTL and testbench
==================================

Name: rgb_pwm_capture

Overview:
- Receive-side counterpart of the RGB PWM generator.
- Samples an asynchronous PWM waveform and measures its period and high time in clk cycles.
- Publishes the result in the same countmax/hivalue form the generator consumes.
- Uses: loopback self-test of LED channels, and decoding PWM brightness commands from an external controller.

Parameters:
- WIDTH, 16, bit width of the counters and the measurement outputs.
- TIMEOUT, 16'hFFFF, cycles without a rising edge before the input is declared stuck (2 <= TIMEOUT <= 2^WIDTH-1).
- FILTER_LEN, 4, consecutive stable samples needed to accept a level change (used only with the filter macro).

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset; 0 = reset, 1 = running.
- pwm_in  in  1  asynchronous PWM input.
- meas_countmax  out  WIDTH  measured period in clk cycles (rise to rise).
- meas_hivalue  out  WIDTH  measured high time in clk cycles (rise to fall).
- meas_valid  out  1  one-cycle strobe when a new measurement pair is loaded.
- timeout  out  1  high while no rising edge has been seen for TIMEOUT cycles.
- stuck_level  out  1  synchronized input level captured when timeout asserted.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear.
  - meas_countmax=0, meas_hivalue=0, meas_valid=0, timeout=0, stuck_level=0.
  - state=IDLE.
  - Reset mid-measurement discards the partial cycle; no strobe is emitted.
- Input front end:
  - 2-FF synchronizer gives pwm_s; one more register gives pwm_d.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
  - Edge strobes appear 3 clk cycles after the pin edge. Both edges see equal delay, so measurements are unaffected.
- Counters:
  - per_cnt: loads 1 on rise, otherwise increments, saturating at TIMEOUT.
  - hi_cnt: loads 1 on rise, increments while pwm_s=1, saturating at TIMEOUT.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for first rise -> HIGH. No measurement is produced, because the first cycle is partial.
  - HIGH: on fall -> latch hi_hold=hi_cnt, go to LOW.
  - LOW: on rise -> load meas_countmax=per_cnt and meas_hivalue=hi_hold, pulse meas_valid the following cycle, clear timeout, go to HIGH.
  - Measurement outputs are updated in the same register stage as meas_valid, so they are stable when meas_valid=1 and hold until the next load.
- Timeout:
  - Trigger: per_cnt reaches TIMEOUT in any state other than IDLE, or TIMEOUT cycles elapse in IDLE since reset or since the last timeout clear.
  - On trigger: timeout=1, stuck_level=pwm_s, meas_countmax=0, meas_hivalue=0, state -> IDLE.
  - No meas_valid pulse on timeout.
  - stuck_level=1 means 100% duty (generator nopulse case); stuck_level=0 means 0% duty.
- Boundaries:
  - rise and timeout in the same cycle: the rise wins, timeout stays 0.
  - 1-cycle high pulse gives meas_hivalue=1.
  - Minimum measurable period is 2.
  - Counters never wrap; saturation plus timeout covers overflow.

Optional Feature:
- Macro: RGB_PWM_CAPTURE_FILTER_EN.
- Defined: a glitch filter sits between the synchronizer and pwm_s. pwm_s changes only after pwm_in has been stable for FILTER_LEN consecutive samples. Pulses shorter than FILTER_LEN are ignored. Edge latency becomes 3+FILTER_LEN cycles.
- Undefined: no filter; every synchronized transition counts.

Decomposition:
- Shared package rgb_pwm_pkg holds:
  - FSM state encoding: IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
  - default WIDTH and TIMEOUT constants, shared with the PWM generator.
- Sub-module pwm_edge_sync contains:
  - synchronizer, optional filter, pwm_s/pwm_d registers.
  - rise/fall outputs, with the same clk and reset.

Test Plan:
- Generator-style waveform, period 10, high 3, run 5 cycles -> first meas_valid after the 2nd rise with meas_countmax=10, meas_hivalue=3; one strobe per subsequent period.
- Period 1000, high 1 -> meas_countmax=1000, meas_hivalue=1; period 2, high 1 -> 2/1.
- pwm_in held high with TIMEOUT=100 after valid traffic -> timeout=1 after 100 cycles, stuck_level=1, meas outputs 0; resume period 10, high 5 -> timeout clears on the first rise, valid 10/5 after the next rise.
- Assert reset for 1 cycle mid-HIGH -> all outputs 0 immediately (asynchronous); no strobe until two full rises after release.
- With RGB_PWM_CAPTURE_FILTER_EN and FILTER_LEN=4: inject a 2-cycle low glitch inside a 20-cycle high phase (period 40) -> measurement stays 40/20, no extra strobe. Without the macro: the glitch produces a shortened measurement.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pwm_pkg : shared constants and capture FSM encoding for the RGB PWM blocks
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package rgb_pwm_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_edge_sync.sv
// ---------------------------------------------------------------------------
// pwm_edge_sync : 2-FF synchronizer, optional glitch filter, rise/fall strobes
// Macro RGB_PWM_CAPTURE_FILTER_EN enables the FILTER_LEN-sample glitch filter
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_edge_sync
`ifdef RGB_PWM_CAPTURE_FILTER_EN
#(
  parameter int FILTER_LEN = 4
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       pwm_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef RGB_PWM_CAPTURE_FILTER_EN
  localparam int            CW   = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] flt_cnt;
  logic          flt_q;

  // Accept a new level only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_cnt <= '0;
      flt_q   <= 1'b0;
    end else if (sync_q[1] == flt_q) begin
      flt_cnt <= '0;
    end else if (flt_cnt == LAST) begin
      flt_q   <= sync_q[1];
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + CW'(1);
    end
  end

  assign pwm_s = flt_q;
`else
  assign pwm_s = sync_q[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_d <= 1'b0;
    end else begin
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_capture.sv
// ---------------------------------------------------------------------------
// rgb_pwm_capture : measures period / high time of an async PWM input
// Macro RGB_PWM_CAPTURE_FILTER_EN inserts a glitch filter in the front end
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rgb_pwm_capture
  import rgb_pwm_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
`ifdef RGB_PWM_CAPTURE_FILTER_EN
  ,
  parameter int FILTER_LEN = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] meas_countmax,
  output logic [WIDTH-1:0] meas_hivalue,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);

  logic             pwm_s, rise, fall;
  logic [WIDTH-1:0] per_cnt, hi_cnt, hi_hold;
  state_t           state, state_nxt;
  logic             to_hit, load_meas, latch_hi;

  pwm_edge_sync
`ifdef RGB_PWM_CAPTURE_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  u_edge (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A rise in the same cycle as saturation wins; an asserted timeout never re-fires
  always_comb begin
    state_nxt = state;
    load_meas = 1'b0;
    latch_hi  = 1'b0;
    to_hit    = (per_cnt == TO_VAL) && !rise && !timeout;
    unique case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: if (fall) begin
        latch_hi  = 1'b1;
        state_nxt = LOW;
      end
      LOW: if (rise) begin
        load_meas = 1'b1;
        state_nxt = HIGH;
      end
      default: state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt       <= '0;
      hi_cnt        <= '0;
      hi_hold       <= '0;
      meas_countmax <= '0;
      meas_hivalue  <= '0;
      meas_valid    <= 1'b0;
      timeout       <= 1'b0;
      stuck_level   <= 1'b0;
    end else begin
      if (rise)                  per_cnt <= WIDTH'(1);
      else if (per_cnt != TO_VAL) per_cnt <= per_cnt + WIDTH'(1);

      if (rise)                           hi_cnt <= WIDTH'(1);
      else if (pwm_s && hi_cnt != TO_VAL) hi_cnt <= hi_cnt + WIDTH'(1);

      if (latch_hi) hi_hold <= hi_cnt;

      meas_valid <= load_meas;
      if (load_meas) begin
        meas_countmax <= per_cnt;
        meas_hivalue  <= hi_hold;
      end else if (to_hit) begin
        meas_countmax <= '0;
        meas_hivalue  <= '0;
      end

      if (rise) begin
        timeout <= 1'b0;
      end else if (to_hit) begin
        timeout     <= 1'b1;
        stuck_level <= pwm_s;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_capture : scoreboard bench, two captures (TIMEOUT 100 and 1000)
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rgb_pwm_capture;

  localparam int W    = 16;
  localparam int TO_A = 100;
  localparam int TO_B = 1000;
`ifdef RGB_PWM_CAPTURE_FILTER_EN
  localparam int MINPH = 4;
  localparam bit FILT  = 1'b1;
`else
  localparam int MINPH = 1;
  localparam bit FILT  = 1'b0;
`endif

  typedef struct {
    int unsigned per;
    int unsigned hi;
  } meas_t;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] cm [2];
  logic [W-1:0] hv [2];
  logic         mv [2];
  logic         tmo[2];
  logic         stk[2];

  int unsigned to_lim[2] = '{TO_A, TO_B};
  meas_t       q[2][$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state: pin-level history in whole clock cycles
  int unsigned cyc = 0, last_rise = 0, hi = 0;
  bit          prev = 1'b0, armed = 1'b0;

  always #5 clk = ~clk;

  rgb_pwm_capture #(.WIDTH(W), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .meas_countmax(cm[0]), .meas_hivalue(hv[0]), .meas_valid(mv[0]),
    .timeout(tmo[0]), .stuck_level(stk[0])
  );

  rgb_pwm_capture #(.WIDTH(W), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .meas_countmax(cm[1]), .meas_hivalue(hv[1]), .meas_valid(mv[1]),
    .timeout(tmo[1]), .stuck_level(stk[1])
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A rise closes the previous period; it is measurable if armed and not longer than TIMEOUT
  task automatic model_step(input bit lvl);
    if (lvl && !prev) begin
      for (int k = 0; k < 2; k++) begin
        if (armed && (cyc - last_rise) <= to_lim[k]) q[k].push_back('{cyc - last_rise, hi});
      end
      armed     = 1'b1;
      last_rise = cyc;
      hi        = 0;
    end
    if (lvl) hi++;
    prev = lvl;
    cyc++;
  endtask

  task automatic drive(input bit pin, input bit mlvl);
    @(negedge clk);
    pwm_in = pin;
    model_step(mlvl);
  endtask

  task automatic run(input int p, input int h, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < p; i++) drive(i < h, i < h);
  endtask

  task automatic hold(input bit lvl, input int n);
    for (int i = 0; i < n; i++) drive(lvl, lvl);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_countmax_%0d", tag, k), cm[k], 0);
      chk($sformatf("%s_hivalue_%0d", tag, k), hv[k], 0);
      chk($sformatf("%s_valid_%0d", tag, k), mv[k], 0);
      chk($sformatf("%s_timeout_%0d", tag, k), tmo[k], 0);
      chk($sformatf("%s_stuck_%0d", tag, k), stk[k], 0);
    end
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    #1 check_all_zero("async_reset");
    for (int k = 0; k < 2; k++) q[k].delete();
    @(negedge clk);
    pwm_in = 1'b0;
    #1 reset = 1'b1;
    prev  = 1'b0;
    armed = 1'b0;
    model_step(1'b0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  initial begin
    meas_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (mv[k] === 1'b1) begin
          if (q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe_%0d: got countmax=%0d hivalue=%0d, expected no strobe (t=%0t)",
                     k, cm[k], hv[k], $time);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("countmax_%0d", k), cm[k], e.per);
            chk($sformatf("hivalue_%0d", k), hv[k], e.hi);
            chk($sformatf("timeout_at_strobe_%0d", k), tmo[k], 0);
          end
        end
      end
    end
  end

  initial begin
    int p, h;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    @(negedge clk);
    pwm_in = 1'b0;
    #1 reset = 1'b1;
    model_step(1'b0);
    hold(1'b0, 5);

    // Generator-style traffic, long/short extremes and the TIMEOUT boundary of dut_a
    run(10, (MINPH > 3) ? MINPH : 3, 5);
    run(1000, MINPH, 3);
    run((MINPH == 1) ? 2 : 2 * MINPH, MINPH, 6);
    run(100, 50, 2);
    run(101, 50, 2);

    // Stuck high: only the short-timeout instance trips
    hold(1'b1, 150);
    chk("stuck_hi_timeout_a", tmo[0], 1);
    chk("stuck_hi_level_a", stk[0], 1);
    chk("stuck_hi_countmax_a", cm[0], 0);
    chk("stuck_hi_hivalue_a", hv[0], 0);
    chk("stuck_hi_timeout_b", tmo[1], 0);
    hold(1'b0, 5);
    hold(1'b1, 5);
    chk("timeout_cleared_by_rise_a", tmo[0], 0);
    hold(1'b0, 5);
    run(10, 5, 3);

    // Stuck low
    hold(1'b0, 150);
    chk("stuck_lo_timeout_a", tmo[0], 1);
    chk("stuck_lo_level_a", stk[0], 0);
    chk("stuck_lo_timeout_b", tmo[1], 0);

    // Reset in the middle of a high phase
    hold(1'b1, 10);
    pulse_reset();
    hold(1'b0, 10);
    run(10, 5, 3);

    // Short low glitch inside the high phase; filtered builds must not see it
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 40; i++) begin
        bit pin;
        pin = (i < 20) && !(i == 8 || i == 9);
        drive(pin, FILT ? (i < 20) : pin);
      end

    // Randomized periods, some beyond dut_a's TIMEOUT
    for (int r = 0; r < 30; r++) begin
      p = $urandom_range(130, 2 * MINPH + ((MINPH == 1) ? 1 : 0));
      h = $urandom_range(p - MINPH, MINPH);
      run(p, h, 1 + ($urandom % 2));
    end

    hold(1'b0, 30);
    for (int k = 0; k < 2; k++) chk($sformatf("pending_expected_%0d", k), q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
